// File: rtl/vector_mem_arb_pkg.sv
// Shared types and constants for the vector/scalar memory-port arbiter.
package vector_mem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Requester-ID width; a single requester still gets one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_ID_W   = id_width(2);
  localparam int REQ_VECTOR = 0;
  localparam int REQ_SCALAR = 1;

  typedef struct packed {
    logic        unit;
    logic [1:0]  sew;
    logic [31:0] addr;
  } req_hdr_t;

endpackage

// File: rtl/vector_mem_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for reads in flight; one pointer bit beyond
// the address separates full from empty.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]             wr_ptr, rd_ptr;
  logic [DEPTH-1:0][W-1:0] mem;
  logic                    do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A same-cycle pop frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Round-robin arbiter for the shared 256-bit memory port, with grant locking
// for multi-beat sequences and in-order read-data steering by requester ID.
module vector_mem_arbiter
  import vector_mem_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_WIDTH      = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid_rd,
  input  logic [NUM_REQ-1:0]                  req_valid_wr,
  input  logic [NUM_REQ-1:0]                  req_unit,
  input  logic [NUM_REQ-1:0][1:0]             req_sew,
  input  logic [NUM_REQ-1:0][31:0]            req_address,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_wr,
  input  logic [NUM_REQ-1:0]                  req_lock,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  input  logic                                mem_ready,
  input  logic                                mem_valid_o,
  input  logic [DATA_WIDTH-1:0]               mem_data_o,
  output logic                                mem_valid_rd,
  output logic                                mem_valid_wr,
  output logic                                mem_unit,
  output logic [1:0]                          mem_sew,
  output logic [31:0]                         mem_address,
  output logic [DATA_WIDTH-1:0]               mem_data_wr,
  output logic                                err_spurious
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   owner, owner_nxt, rr_ptr, rr_nxt, win, head;
  logic [NUM_REQ-1:0] req_any;
  logic              found, win_rd, win_wr, accept;
  logic              fifo_full, fifo_empty, pop, slot_ok;
  req_hdr_t          hdr;

  assign req_any = req_valid_rd | req_valid_wr;

  // Winner: the owner while locked, else first active requester from rr_ptr.
  always_comb begin : pick
    int              idx;
    logic [ID_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    if (state == LOCKED) begin
      found = req_any[owner];
      win   = owner;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = ID_W'(idx);
        if (!found && req_any[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  assign pop     = mem_valid_o & ~fifo_empty;
  assign slot_ok = ~fifo_full | pop;
  assign win_rd  = found & req_valid_rd[win];
  assign win_wr  = found & req_valid_wr[win] & ~req_valid_rd[win];

  assign mem_valid_rd = rst & win_rd & mem_ready & slot_ok;
  assign mem_valid_wr = rst & win_wr & mem_ready;
  assign accept       = mem_valid_rd | mem_valid_wr;

  always_comb begin
    req_ready   = '0;
    hdr         = '0;
    mem_data_wr = '0;
    if (accept) req_ready[win] = 1'b1;
    if (rst && found) begin
      hdr.unit    = req_unit[win];
      hdr.sew     = req_sew[win];
      hdr.addr    = req_address[win];
      mem_data_wr = req_data_wr[win];
    end
  end

  assign mem_unit    = hdr.unit;
  assign mem_sew     = hdr.sew;
  assign mem_address = hdr.addr;

  // Read data returns in order; the FIFO head names its requester.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (pop) begin
      rsp_valid[head] = 1'b1;
      rsp_data        = mem_data_o;
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (mem_valid_rd),
    .pop   (pop),
    .din   (win),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    case (state)
      ARB: begin
        if (accept) begin
          rr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          if (req_lock[win]) begin
            state_nxt = LOCKED;
            owner_nxt = win;
          end
        end
      end
      LOCKED: begin
        // Release only on an idle cycle so a beat in flight keeps ownership.
        if (!req_lock[owner] && !accept) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB;
      owner        <= '0;
      rr_ptr       <= '0;
      err_spurious <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
      if (mem_valid_o && fifo_empty) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Directed bench for vector_mem_arbiter: a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_vector_mem_arbiter;

  localparam int N    = 2;
  localparam int MAXO = 4;
  localparam int DW   = 256;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [N-1:0]            req_valid_rd = '0;
  logic [N-1:0]            req_valid_wr = '0;
  logic [N-1:0]            req_unit = '0;
  logic [N-1:0][1:0]       req_sew = '0;
  logic [N-1:0][31:0]      req_address = '0;
  logic [N-1:0][DW-1:0]    req_data_wr = '0;
  logic [N-1:0]            req_lock = '0;
  logic [N-1:0]            req_ready, rsp_valid;
  logic [DW-1:0]           rsp_data;
  logic                    mem_ready = 1'b0;
  logic                    mem_valid_o = 1'b0;
  logic [DW-1:0]           mem_data_o = '0;
  logic                    mem_valid_rd, mem_valid_wr, mem_unit;
  logic [1:0]              mem_sew;
  logic [31:0]             mem_address;
  logic [DW-1:0]           mem_data_wr;
  logic                    err_spurious;

  int n_checks = 0;
  int n_fail   = 0;

  vector_mem_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_rd(req_valid_rd), .req_valid_wr(req_valid_wr), .req_unit(req_unit),
    .req_sew(req_sew), .req_address(req_address), .req_data_wr(req_data_wr),
    .req_lock(req_lock), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_ready(mem_ready), .mem_valid_o(mem_valid_o), .mem_data_o(mem_data_o),
    .mem_valid_rd(mem_valid_rd), .mem_valid_wr(mem_valid_wr), .mem_unit(mem_unit),
    .mem_sew(mem_sew), .mem_address(mem_address), .mem_data_wr(mem_data_wr),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: grant ownership, round-robin pointer, queue of read IDs.
  int    m_rr = 0;
  int    m_owner = 0;
  bit    m_locked = 0;
  bit    m_err = 0;
  int    m_q[$];

  task automatic model_step();
    bit            found, pop, slot, e_rd, e_wr, acc;
    int            w, j;
    logic [N-1:0]  e_rdy, e_rsp;
    logic [DW-1:0] e_rdata, e_dwr;
    logic [31:0]   e_addr;
    logic [1:0]    e_sew;
    logic          e_unit;
    if (!rst) begin
      m_rr = 0; m_locked = 0; m_err = 0; m_q.delete();
    end
    found = 0; w = 0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        j = (m_rr + i) % N;
        if (!found && (!m_locked || j == m_owner) && (req_valid_rd[j] || req_valid_wr[j])) begin
          found = 1; w = j;
        end
      end
    end
    pop  = rst && mem_valid_o && (m_q.size() > 0);
    slot = (m_q.size() < MAXO) || pop;
    e_rd = found && req_valid_rd[w] && mem_ready && slot;
    e_wr = found && req_valid_wr[w] && !req_valid_rd[w] && mem_ready;
    acc  = e_rd || e_wr;
    e_rdy = '0;
    if (acc) e_rdy[w] = 1'b1;
    e_unit = found ? req_unit[w] : 1'b0;
    e_sew  = found ? req_sew[w] : 2'b0;
    e_addr = found ? req_address[w] : 32'h0;
    e_dwr  = found ? req_data_wr[w] : '0;
    e_rsp = '0; e_rdata = '0;
    if (pop) begin
      e_rsp[m_q[0]] = 1'b1;
      e_rdata = mem_data_o;
    end
    check("req_ready", DW'(req_ready), DW'(e_rdy));
    check("mem_valid_rd", DW'(mem_valid_rd), DW'(e_rd));
    check("mem_valid_wr", DW'(mem_valid_wr), DW'(e_wr));
    check("mem_unit", DW'(mem_unit), DW'(e_unit));
    check("mem_sew", DW'(mem_sew), DW'(e_sew));
    check("mem_address", DW'(mem_address), DW'(e_addr));
    check("mem_data_wr", mem_data_wr, e_dwr);
    check("rsp_valid", DW'(rsp_valid), DW'(e_rsp));
    check("rsp_data", rsp_data, e_rdata);
    check("err_spurious", DW'(err_spurious), DW'(m_err));
    if (rst) begin
      if (pop) void'(m_q.pop_front());
      else if (mem_valid_o) m_err = 1;
      if (e_rd) m_q.push_back(w);
      if (!m_locked) begin
        if (acc) begin
          m_rr = (w + 1) % N;
          if (req_lock[w]) begin m_locked = 1; m_owner = w; end
        end
      end else if (!req_lock[m_owner] && !acc) begin
        m_locked = 0;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // Auto-responding memory: returns each accepted read one cycle later.
  bit          auto_rsp = 1;
  logic        acc_q = 1'b0;
  logic [31:0] addr_q = '0;
  always @(negedge clk) begin
    acc_q  <= mem_valid_rd;
    addr_q <= mem_address;
  end
  always @(posedge clk) begin
    #2;
    if (auto_rsp) begin
      mem_valid_o = acc_q;
      mem_data_o  = {8{addr_q}};
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  initial begin
    logic [31:0]   a;
    logic [DW-1:0] d;
    req_sew[0] = 2'd2; req_sew[1] = 2'd0; req_unit = 2'b01;
    req_data_wr[0] = {8{32'hA5A5_0000}};
    req_data_wr[1] = {8{32'h0000_5A5A}};
    // Reset then idle
    tick(); tick();
    mid();
    check("lit_rst_ready", DW'(req_ready), '0);
    check("lit_rst_rd", DW'(mem_valid_rd), '0);
    check("lit_rst_err", DW'(err_spurious), '0);
    tick(); rst = 1'b1; mem_ready = 1'b1;
    mid();
    check("lit_idle_ready", DW'(req_ready), '0);
    check("lit_idle_addr", DW'(mem_address), '0);
    tick();

    // Contention fairness
    req_valid_rd = 2'b11;
    req_address[0] = 32'h100; req_address[1] = 32'h200;
    for (int k = 0; k < 6; k++) begin
      mid();
      check("lit_fair_ready", DW'(req_ready), (k % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
      if (k == 0) check("lit_fair_rsp0", DW'(rsp_valid), '0);
      else begin
        a = ((k - 1) % 2 == 0) ? 32'h100 : 32'h200;
        check("lit_fair_rsp", DW'(rsp_valid), ((k - 1) % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
        check("lit_fair_data", rsp_data, {8{a}});
      end
      tick();
    end
    req_valid_rd = 2'b00;
    mid();
    check("lit_fair_last", DW'(rsp_valid), DW'(2'b10));
    tick();

    // Lock: vector holds the port for 8 strided beats
    req_valid_rd = 2'b11; req_lock = 2'b01;
    for (int i = 0; i < 8; i++) begin
      req_address[0] = 32'(4 * i);
      mid();
      check("lit_lock_ready", DW'(req_ready), DW'(2'b01));
      check("lit_lock_addr", DW'(mem_address), DW'(32'(4 * i)));
      tick();
    end
    req_valid_rd = 2'b10; req_lock = 2'b00;
    mid();
    check("lit_unlock_hold", DW'(req_ready), '0);
    tick();
    mid();
    check("lit_unlock_grant", DW'(req_ready), DW'(2'b10));
    tick();
    req_valid_rd = 2'b00;
    tick(); tick();

    // FIFO full: four reads in flight, no returns
    auto_rsp = 0; mem_valid_o = 1'b0;
    req_valid_rd = 2'b01; req_address[0] = 32'h300;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("lit_fill_ready", DW'(req_ready), DW'(2'b01));
      tick();
    end
    mid();
    check("lit_full_ready", DW'(req_ready), '0);
    check("lit_full_rd", DW'(mem_valid_rd), '0);
    tick();
    d = {8{32'hDEAD_BEEF}};
    mem_valid_o = 1'b1; mem_data_o = d;
    mid();
    check("lit_relief_ready", DW'(req_ready), DW'(2'b01));
    check("lit_relief_rsp", DW'(rsp_valid), DW'(2'b01));
    check("lit_relief_data", rsp_data, d);
    tick();
    mem_valid_o = 1'b0;
    mid();
    check("lit_still_full", DW'(req_ready), '0);
    tick();
    req_valid_rd = 2'b00;

    // Write passes a full FIFO
    req_valid_wr = 2'b10; req_address[1] = 32'h40;
    mid();
    check("lit_wr_valid", DW'(mem_valid_wr), DW'(1'b1));
    check("lit_wr_ready", DW'(req_ready), DW'(2'b10));
    check("lit_wr_addr", DW'(mem_address), DW'(32'h40));
    tick();
    mem_ready = 1'b0;
    mid();
    check("lit_wr_stall", DW'(req_ready), '0);
    check("lit_wr_stall_v", DW'(mem_valid_wr), '0);
    tick();
    req_valid_wr = 2'b00; mem_ready = 1'b1;

    // Reset with reads outstanding, then stray read data
    rst = 1'b0;
    mid();
    check("lit_mid_rst_err", DW'(err_spurious), '0);
    tick();
    rst = 1'b1;
    mid();
    tick();
    mem_valid_o = 1'b1; mem_data_o = {8{32'h1234_5678}};
    mid();
    check("lit_spur_rsp", DW'(rsp_valid), '0);
    check("lit_spur_data", rsp_data, '0);
    tick();
    mem_valid_o = 1'b0;
    mid();
    check("lit_spur_err", DW'(err_spurious), DW'(1'b1));
    tick(); tick();
    req_valid_rd = 2'b10; req_address[1] = 32'h80;
    mid();
    check("lit_spur_held", DW'(err_spurious), DW'(1'b1));
    check("lit_post_rst_grant", DW'(req_ready), DW'(2'b10));
    tick();
    req_valid_rd = 2'b00;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
